// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the two-port RAM arbiter
package ram_arb_pkg;

    localparam int MAX_BURST_DEF = 4;
    localparam int PRIO_DEF      = 0;

    // Grant history: which requester won the most recent accepted access
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_0    = 2'd1,
        OWN_1    = 2'd2
    } owner_t;

    // Registered command driven to the RAM one cycle after accept
    typedef struct packed {
        logic       valid;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       id;
    } ram_cmd_t;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - combinational winner/grant selection with burst limiting
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int PRIO      = PRIO_DEF
) (
    input  logic       req0,
    input  logic       req1,
    input  owner_t     owner,
    input  logic [3:0] burst_cnt,
    output logic       win_valid,
    output logic       win_id,
    output logic       gnt0,
    output logic       gnt1
);

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
    localparam logic       PRIO_ID   = (PRIO != 0);

    // Pick the winner; under contention the last winner keeps the RAM until its burst is used up
    always_comb begin
        win_valid = req0 | req1;
        win_id    = req1;
        if (req0 && req1) begin
            case (owner)
                OWN_0:   win_id = (burst_cnt < BURST_LIM) ? 1'b0 : 1'b1;
                OWN_1:   win_id = (burst_cnt < BURST_LIM) ? 1'b1 : 1'b0;
                default: win_id = PRIO_ID;
            endcase
        end
        gnt0 = win_valid & ~win_id;
        gnt1 = win_valid &  win_id;
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one 256x8 single-port RAM between two requesters
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int PRIO      = PRIO_DEF
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       rvalid0,
    output logic       rvalid1,
    output logic       n_cs,
    output logic       n_oe,
    output logic       n_we,
    output logic [7:0] ram_address,
    output logic [7:0] ram_data_in,
    input  logic [7:0] ram_data_out
);

    owner_t     owner_q, owner_d;
    logic [3:0] burst_q, burst_d;
    ram_cmd_t   cmd_q, cmd_d;
    logic [7:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic       rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;

    logic win_valid, win_id, pick_gnt0, pick_gnt1, accept;

    ram_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .PRIO      (PRIO)
    ) u_pick (
        .req0      (req0),
        .req1      (req1),
        .owner     (owner_q),
        .burst_cnt (burst_q),
        .win_valid (win_valid),
        .win_id    (win_id),
        .gnt0      (pick_gnt0),
        .gnt1      (pick_gnt1)
    );

    // Grants are suppressed while reset is held so nothing is advertised as accepted
    assign gnt0   = pick_gnt0 & n_reset;
    assign gnt1   = pick_gnt1 & n_reset;
    assign accept = win_valid & n_reset;

    // Next command, grant history and burst count; idle cycles keep history and address/data
    always_comb begin
        cmd_d       = cmd_q;
        cmd_d.valid = 1'b0;
        owner_d     = owner_q;
        burst_d     = burst_q;
        if (accept) begin
            cmd_d.valid = 1'b1;
            cmd_d.we    = win_id ? we1    : we0;
            cmd_d.addr  = win_id ? addr1  : addr0;
            cmd_d.wdata = win_id ? wdata1 : wdata0;
            cmd_d.id    = win_id;
            owner_d     = win_id ? OWN_1 : OWN_0;
            if (owner_q == owner_d) begin
                burst_d = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
            end else begin
                burst_d = 4'd1;
            end
        end
    end

    // Read return: capture RAM data at the end of the read cycle and route it by requester id
    always_comb begin
        rvalid0_d = cmd_q.valid & ~cmd_q.we & ~cmd_q.id;
        rvalid1_d = cmd_q.valid & ~cmd_q.we &  cmd_q.id;
        rdata0_d  = rvalid0_d ? ram_data_out : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_data_out : rdata1_q;
    end

    // State registers; reset clears the command so the strobes drop without a clock
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            owner_q   <= OWN_NONE;
            burst_q   <= 4'd0;
            cmd_q     <= '0;
            rdata0_q  <= 8'd0;
            rdata1_q  <= 8'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            burst_q   <= burst_d;
            cmd_q     <= cmd_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign n_cs        = ~cmd_q.valid;
    assign n_oe        = ~(cmd_q.valid & ~cmd_q.we);
    assign n_we        = ~(cmd_q.valid &  cmd_q.we);
    assign ram_address = cmd_q.addr;
    assign ram_data_in = cmd_q.wdata;
    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign rvalid0     = rvalid0_q;
    assign rvalid1     = rvalid1_q;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter that shares the single-port 256x8 data RAM between the CPU datapath (requester 0) and a loader/DMA port (requester 1). It accepts at most one access per clock, drives the RAM's active-low `n_cs`/`n_oe`/`n_we` strobes, address and write data from a registered command stage, and returns read data to the requester that issued the read. It sits between the datapath's RAM port and the RAM instance.

## Interface
Parameters:
- `MAX_BURST`, default 4: maximum consecutive grants to one requester while the other requester is also requesting; range 1..15.
- `PRIO`, default 0: requester that wins a tie when there is no grant history.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `n_reset`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  access request; held until granted.
- `we0`, `we1`  in  1  1 = write, 0 = read; valid while `reqN`=1.
- `addr0`, `addr1`  in  8  RAM byte address.
- `wdata0`, `wdata1`  in  8  write data.
- `gnt0`, `gnt1`  out  1  combinational; the request is accepted at a rising edge where `reqN && gntN`.
- `rdata0`, `rdata1`  out  8  read data; holds its value until the next read return to that requester.
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse marking new `rdataN`.
- `n_cs`, `n_oe`, `n_we`  out  1  RAM strobes, active-low.
- `ram_address`  out  8  RAM address.
- `ram_data_in`  out  8  RAM write data.
- `ram_data_out`  in  8  RAM combinational read data.

## Operation
- History state: `OWN_NONE`, `OWN_0`, `OWN_1` (last winner), plus a 4-bit `burst_cnt`.
- Winner selection in each cycle (combinational):
  - No request: no grant.
  - One request: that requester wins.
  - Both requesting, history `OWN_NONE`: `PRIO` wins.
  - Both requesting, last winner L: L wins if `burst_cnt < MAX_BURST`; otherwise the other requester wins.
- `gntN` = 1 only for the winner, and only when `reqN`=1. The two grants are never both 1.
- On accept: the command register loads {valid=1, we, addr, wdata, id}.
  - If the winner equals the last winner, `burst_cnt` increments, saturating at 15; otherwise `burst_cnt` = 1.
  - History is set to the winner.
- No accept: command valid=0. History is kept and `burst_cnt` is kept, so contention arriving later is judged against the same counter.
- RAM drive, taken from the command register:
  - Read: `n_cs`=0, `n_oe`=0, `n_we`=1.
  - Write: `n_cs`=0, `n_oe`=1, `n_we`=0.
  - Invalid: all three strobes = 1; `ram_address` and `ram_data_in` hold their last values.
- Read return: on the rising edge ending the RAM cycle, `rdata[id]` <= `ram_data_out` and `rvalid[id]` <= 1 for one cycle. Writes produce no response.
- Accesses complete in grant order. A read granted after a write to the same address returns the new data.

## Timing
- Cycle N: request with grant asserted, accepted at the end of N.
- Cycle N+1: strobes, address and data driven to the RAM. A write commits at the end of N+1.
- Cycle N+2: `rvalidN`=1 and `rdataN` valid for a read. Read latency is 2 cycles from accept.
- Throughput: one access per cycle, fully pipelined. Back-to-back grants to the same or alternating requesters are allowed.
- Reset values (asynchronous on `n_reset`=0): `n_cs`=`n_oe`=`n_we`=1; `ram_address`=0; `ram_data_in`=0; `rdata0`=`rdata1`=0; `rvalid0`=`rvalid1`=0; `gnt0`=`gnt1`=0 while in reset; command valid=0; history `OWN_NONE`; `burst_cnt`=0.
- Reset mid-operation:
  - A pending write that has not yet reached its commit edge is dropped.
  - A pending read produces no `rvalid`.
  - Strobes deassert immediately, without waiting for a clock.
- A requester that drops `req` without a grant cancels its request; no state changes.

## Structure
- Shared package `ram_arb_pkg`:
  - `owner_t` enum (`OWN_NONE`, `OWN_0`, `OWN_1`).
  - `ram_cmd_t` struct {valid, we, addr[7:0], wdata[7:0], id}.
  - Default constants `MAX_BURST_DEF`=4 and `PRIO_DEF`=0.
- Sub-module `ram_arb_pick`: purely combinational winner and grant selection from `req0`, `req1`, history, `burst_cnt`, `MAX_BURST` and `PRIO`.
- Top level holds the history and burst counter, the command register, strobe decode and read-return registers.

## Test plan
- Reset: hold `n_reset`=0 with both `req` = 1 → strobes all 1, grants 0, `rdata`=0, `rvalid`=0; release → `gnt0`=1 first cycle (`PRIO`=0).
- Requester 0 writes 0xA5 to 0x10, then reads 0x10 → `n_we`=0 with `ram_address`=0x10 one cycle after the first accept; `rvalid0`=1 with `rdata0`=0xA5 two cycles after the read accept; `rvalid1` stays 0.
- Both requesters request reads continuously (`MAX_BURST`=4) → grants 0,0,0,0,1,1,1,1,0,…; each `rvalid` appears exactly 2 cycles after its accept, routed to the correct `rdataN`.
- Requester 1 alone requests for 10 cycles, then requester 0 joins → requester 1 is granted all 10 cycles, then `gnt0`=1 on the first contended cycle, since `burst_cnt` saturated ≥ 4.
- Same cycle: requester 1 writes 0x3C to 0x20 while requester 0 reads 0x20 (`PRIO`=0) → the read wins and returns the old value; the write follows next cycle; a second read of 0x20 returns 0x3C.
- Read accepted, then `n_reset` asserted during the RAM cycle → strobes go high asynchronously; no `rvalid` pulse after release.
